// File: rtl/nibble_pixel_packer.sv
// -----------------------------------------------------------------------------
// nibble_pixel_packer
//
// Purpose:
//   Pairs decoded 4-bit nibbles (high half first) into 8-bit grayscale pixels.
//   Each pixel is tagged with start-of-frame / end-of-line / end-of-frame
//   markers from a running column/row position. Pixel and tags are then buffered
//   in a small FIFO and presented on a valid/ready stream.
//
// Ports:
//   clk         system clock; all logic runs on posedge
//   start       asynchronous active-low reset (0 = reset)
//   nib_valid   one-cycle strobe, nib_data holds a decoded nibble
//   nib_data    decoded nibble
//   pix_valid   FIFO non-empty; pix_data/pix_sof/pix_eol/pix_eof are valid
//   pix_ready   downstream accepts the head pixel when pix_valid & pix_ready
//   pix_data    pixel value
//   pix_sof     pixel is row 0, col 0
//   pix_eol     pixel is col IMG_WIDTH-1
//   pix_eof     pixel is row IMG_HEIGHT-1, col IMG_WIDTH-1
//   overflow    sticky: a completed pixel was dropped because the FIFO was full
//   frame_done  one-cycle pulse after the EOF pixel is accepted downstream
// -----------------------------------------------------------------------------
module nibble_pixel_packer #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       start,
    input  logic       nib_valid,
    input  logic [3:0] nib_data,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [7:0] pix_data,
    output logic       pix_sof,
    output logic       pix_eol,
    output logic       pix_eof,
    output logic       overflow,
    output logic       frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    // FIFO entry layout: {eof, eol, sof, data[7:0]}
    localparam int ENTRY_W = 11;

    logic                half_reg;
    logic [3:0]          hi_nib_reg;
    logic [COL_W-1:0]    col_reg;
    logic [ROW_W-1:0]    row_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                overflow_reg;
    logic                frame_done_reg;
    logic [ENTRY_W-1:0]  entry_mem [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                wr_en;
    logic                fifo_full;
    logic                fifo_empty;
    logic                col_at_end;
    logic                row_at_end;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;

    // A pixel completes on the second nibble of a pair.
    assign push       = nib_valid & half_reg;
    assign fifo_full  = (count_reg == CNT_FULL);
    assign fifo_empty = (count_reg == '0);
    assign pop        = ~fifo_empty & pix_ready;
    // When full, a simultaneous pop frees the head slot, so the push still lands.
    assign wr_en      = push & (~fifo_full | pop);

    assign col_at_end = (col_reg == COL_LAST);
    assign row_at_end = (row_reg == ROW_LAST);

    assign push_entry = {col_at_end & row_at_end,
                         col_at_end,
                         (col_reg == '0) & (row_reg == '0),
                         hi_nib_reg,
                         nib_data};

    assign head_entry = entry_mem[rd_ptr_reg];

    // Head fields are gated so the stream reads as zero while empty (and out of
    // reset, before storage has ever been written).
    assign pix_valid  = ~fifo_empty;
    assign pix_data   = pix_valid ? head_entry[7:0] : 8'h00;
    assign pix_sof    = pix_valid & head_entry[8];
    assign pix_eol    = pix_valid & head_entry[9];
    assign pix_eof    = pix_valid & head_entry[10];
    assign overflow   = overflow_reg;
    assign frame_done = frame_done_reg;

    // Pixel storage: no reset needed, contents are only observed through count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            half_reg       <= 1'b0;
            hi_nib_reg     <= 4'h0;
            col_reg        <= '0;
            row_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            if (nib_valid) begin
                half_reg <= ~half_reg;
                if (!half_reg) begin
                    hi_nib_reg <= nib_data;
                end
            end

            // Position advances on every completed pixel, dropped or not, so
            // the frame geometry stays locked to the sender.
            if (push) begin
                if (col_at_end) begin
                    col_reg <= '0;
                    row_reg <= row_at_end ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end

            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end

            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (push && !wr_en) begin
                overflow_reg <= 1'b1;
            end

            frame_done_reg <= pop & head_entry[10];
        end
    end

endmodule

// File: tb/tb_nibble_pixel_packer.sv
// -----------------------------------------------------------------------------
// tb_nibble_pixel_packer
//
// Directed bench for nibble_pixel_packer with a 4x2 frame and a 4-entry FIFO.
// A negedge monitor records every accepted pixel as {eof, eol, sof, data} and
// counts frame_done cycles; tests compare those records against hand-written
// expectations.
// -----------------------------------------------------------------------------
module tb_nibble_pixel_packer;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 4;
    localparam int FRAME = W * H;

    logic       clk;
    logic       start;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_sof;
    logic       pix_eol;
    logic       pix_eof;
    logic       overflow;
    logic       frame_done;

    int vec_cnt = 0;
    int err_cnt = 0;
    int fd_cnt  = 0;
    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];

    nibble_pixel_packer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .FIFO_DEPTH(D)
    ) dut (
        .clk       (clk),
        .start     (start),
        .nib_valid (nib_valid),
        .nib_data  (nib_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof),
        .overflow  (overflow),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge, half a cycle away from the active edge.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) got_q.push_back({pix_eof, pix_eol, pix_sof, pix_data});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("[%0d] %s ok (%0h)", vec_cnt, tag, obs);
        end
    endtask

    // Expected entry for a pixel at frame position pos (0..FRAME-1).
    function automatic logic [10:0] ent(input logic [7:0] d, input int pos);
        logic sof, eol, eof;
        sof = (pos == 0);
        eol = ((pos % W) == W - 1);
        eof = (pos == FRAME - 1);
        return {eof, eol, sof, d};
    endfunction

    // Called just after a posedge; returns just after the strobe edge.
    task automatic send_nib(input logic [3:0] n);
        nib_valid = 1'b1;
        nib_data  = n;
        @(posedge clk); #1;
        nib_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] p);
        send_nib(p[7:4]);
        send_nib(p[3:0]);
    endtask

    task automatic do_reset();
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        got_q.delete();
        fd_cnt = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_pix [8];
        logic [7:0] p;
        start     = 1'b0;
        nib_valid = 1'b0;
        nib_data  = 4'h0;
        pix_ready = 1'b0;
        @(posedge clk); #1;

        // ---- Test 1: reset state and single pixel latency ----
        chk("rst pix_valid",  pix_valid,  0);
        chk("rst pix_data",   pix_data,   0);
        chk("rst tags",       {pix_sof, pix_eol, pix_eof}, 0);
        chk("rst overflow",   overflow,   0);
        chk("rst frame_done", frame_done, 0);
        do_reset();
        pix_ready = 1'b1;
        send_nib(4'hA);
        chk("t1 valid before 2nd", pix_valid, 0);
        send_nib(4'h5);
        chk("t1 valid", pix_valid, 1);
        chk("t1 entry", {pix_eof, pix_eol, pix_sof, pix_data}, 11'h1A5);
        cycles(1);
        chk("t1 valid one cycle", pix_valid, 0);
        chk("t1 pops", got_q.size(), 1);

        // ---- Test 2: one full frame, then the next frame's SOF ----
        do_reset();
        pix_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_nib(4'(i));
        cycles(4);
        exp_pix = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        chk("t2 count", got_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got_q.size()) chk($sformatf("t2 pix%0d", i), got_q[i], ent(exp_pix[i], i));
        chk("t2 frame_done", fd_cnt, 1);
        send_nib(4'h1);
        send_nib(4'h2);
        cycles(2);
        chk("t2 count2", got_q.size(), 9);
        if (got_q.size() > 8) chk("t2 next sof", got_q[8], ent(8'h12, 0));

        // ---- Test 3: overflow with stalled downstream ----
        do_reset();
        pix_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            p = {4'(k), 4'(15 - k)};
            send_pix(p);
            chk($sformatf("t3 ovf after pix%0d", k), overflow, (k >= 4) ? 1 : 0);
        end
        chk("t3 held valid", pix_valid, 1);
        pix_ready = 1'b1;
        cycles(8);
        chk("t3 drained", got_q.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got_q.size()) chk($sformatf("t3 held%0d", k), got_q[k], ent({4'(k), 4'(15 - k)}, k));
        // 10 positions consumed; the next pixels sit at positions 2..7 then 0.
        for (int j = 0; j < 7; j++) send_pix({4'(j), 4'hA});
        cycles(3);
        chk("t3 post count", got_q.size(), 11);
        for (int j = 0; j < 7; j++)
            if (4 + j < got_q.size())
                chk($sformatf("t3 post%0d", j), got_q[4 + j], ent({4'(j), 4'hA}, (10 + j) % FRAME));
        chk("t3 frame_done", fd_cnt, 1);
        chk("t3 ovf sticky", overflow, 1);

        // ---- Test 4: push and pop together while full ----
        do_reset();
        pix_ready = 1'b0;
        send_pix(8'h11);
        send_pix(8'h22);
        send_pix(8'h33);
        send_pix(8'h44);
        send_nib(4'h5);
        nib_valid = 1'b1;
        nib_data  = 4'h5;
        pix_ready = 1'b1;
        @(posedge clk); #1;
        nib_valid = 1'b0;
        pix_ready = 1'b0;
        chk("t4 overflow", overflow, 0);
        chk("t4 still full", pix_valid, 1);
        pix_ready = 1'b1;
        cycles(8);
        chk("t4 count", got_q.size(), 5);
        exp_pix = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++)
            if (i < got_q.size()) chk($sformatf("t4 pix%0d", i), got_q[i], ent(exp_pix[i], i));

        // ---- Test 5: reset with a half nibble pending ----
        do_reset();
        pix_ready = 1'b1;
        send_nib(4'h7);
        do_reset();
        pix_ready = 1'b1;
        send_nib(4'h3);
        chk("t5 no stale pixel", pix_valid, 0);
        send_nib(4'hC);
        chk("t5 entry", {pix_eof, pix_eol, pix_sof, pix_data}, 11'h13C);
        cycles(2);
        chk("t5 count", got_q.size(), 1);

        // ---- Test 6: random strobes and backpressure over 3 frames ----
        do_reset();
        exp_q.delete();
        begin
            int   nsent = 0;
            int   pos = 0;
            int   zero_run = 0;
            logic mhalf = 1'b0;
            logic [3:0] mhi = 4'h0;
            logic last_strobe = 1'b0;
            for (int c = 0; c < 4000 && nsent < 6 * FRAME; c++) begin
                // At most 3 stalled cycles in a row, at most one strobe every
                // other cycle: the 4-deep FIFO cannot fill.
                if (zero_run >= 3) pix_ready = 1'b1;
                else pix_ready = 1'($urandom_range(0, 1));
                zero_run = pix_ready ? 0 : zero_run + 1;
                if (!last_strobe && $urandom_range(0, 1) == 1) begin
                    nib_valid = 1'b1;
                    nib_data  = 4'($urandom_range(0, 15));
                    if (!mhalf) begin
                        mhi = nib_data;
                    end else begin
                        exp_q.push_back(ent({mhi, nib_data}, pos));
                        pos = (pos + 1) % FRAME;
                    end
                    mhalf = ~mhalf;
                    nsent++;
                    last_strobe = 1'b1;
                end else begin
                    nib_valid = 1'b0;
                    last_strobe = 1'b0;
                end
                @(posedge clk); #1;
            end
            nib_valid = 1'b0;
            chk("t6 nibbles sent", nsent, 6 * FRAME);
        end
        pix_ready = 1'b1;
        cycles(20);
        chk("t6 count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("t6 pix%0d", i), got_q[i], exp_q[i]);
        chk("t6 frame_done", fd_cnt, 3);
        chk("t6 overflow", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
